// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic inter-stage registers of the pipelined
// RV32I core.
//   - pipe_state_t : occupancy state of one elastic stage (EMPTY/ONE/TWO)
//   - XLEN, REG_AW : RV32 datapath and register-address widths
//   - <STAGE>_CTRL_W / <STAGE>_DATA_W : field widths for each stage instance
//   - stage_occupied / stage_accepts : occupancy-to-handshake helpers
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Occupancy of a stage: number of payloads currently held.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } pipe_state_t;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // IF/ID: no control bits are produced yet; a single spare bit keeps the
    // ctrl vector non-empty. Data = Instr, PC, PCPlus4.
    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 3 * XLEN;

    // ID/EX: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc,
    // ALUControl[2:0]. Data = RD1, RD2, PC, ImmExt, PCPlus4, Rd.
    localparam int ID_EX_CTRL_W  = 10;
    localparam int ID_EX_DATA_W  = 5 * XLEN + REG_AW;

    // EX/MEM: RegWrite, ResultSrc[1:0], MemWrite.
    // Data = ALUResult, WriteData, PCPlus4, Rd.
    localparam int EX_MEM_CTRL_W = 4;
    localparam int EX_MEM_DATA_W = 3 * XLEN + REG_AW;

    // MEM/WB: RegWrite, ResultSrc[1:0]. Data = ALUResult, ReadData, PCPlus4, Rd.
    localparam int MEM_WB_CTRL_W = 3;
    localparam int MEM_WB_DATA_W = 3 * XLEN + REG_AW;

    // A stage presents a payload downstream whenever it holds at least one.
    function automatic logic stage_occupied(input pipe_state_t st);
        logic occ;
        case (st)
            EMPTY:   occ = 1'b0;
            ONE:     occ = 1'b1;
            TWO:     occ = 1'b1;
            default: occ = 1'b0;
        endcase
        return occ;
    endfunction

    // A stage can take a new payload as long as the skid entry is free.
    function automatic logic stage_accepts(input pipe_state_t st);
        logic acc;
        case (st)
            EMPTY:   acc = 1'b1;
            ONE:     acc = 1'b1;
            TWO:     acc = 1'b0;
            default: acc = 1'b1;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// -----------------------------------------------------------------------------
// pipe_entry
// One payload slot (control + data) of an elastic pipeline stage.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset (clears all)
//   load        : capture d_ctrl/d_data
//   ctrl_clear  : zero the control field only (bubble); data is kept
//   d_ctrl/d_data : next payload
//   q_ctrl/q_data : stored payload
// load has priority over ctrl_clear; the parent never asserts both.
// -----------------------------------------------------------------------------
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              ctrl_clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Control field: reset and bubble both force it to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else if (load) begin
            ctrl_r <= d_ctrl;
        end else if (ctrl_clear) begin
            ctrl_r <= {CTRL_W{1'b0}};
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Data field: only reset clears it, bubbles leave the last value in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {DATA_W{1'b0}};
        end else if (load) begin
            data_r <= d_data;
        end else begin
            data_r <= data_r;
        end
    end

    assign q_ctrl = ctrl_r;
    assign q_data = data_r;

endmodule

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic inter-stage register with a 2-entry skid buffer, so in_ready is a
// flop and never a combinational function of out_ready.
// Ports:
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready registered)
//   in_ctrl/in_data       : upstream payload
//   flush                 : drop held entries and the current input beat
//   out_valid/out_ready   : downstream handshake (out_valid registered)
//   out_ctrl/out_data     : downstream payload (ctrl is 0 while out_valid=0,
//                           data holds its last value)
//   stall_cnt             : saturating count of out_valid & !out_ready cycles
// The main entry always drives the outputs; the skid entry catches the one
// beat that can arrive while the downstream is stalled.
// -----------------------------------------------------------------------------
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 101,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state_r;
    pipe_state_t       next_state_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              acc_s;
    logic              emi_s;
    logic              main_load_s;
    logic              main_from_skid_s;
    logic              main_clr_s;
    logic              skid_load_s;
    logic              skid_clr_s;

    logic [CTRL_W-1:0] main_d_ctrl_s;
    logic [DATA_W-1:0] main_d_data_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;

    // Saturating +1 so a long stall does not wrap back to a small count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    assign acc_s = in_valid & in_ready_r;
    assign emi_s = out_valid_r & out_ready;

    // Next-state and entry-control decode; flush overrides any handshake.
    always_comb begin
        next_state_s     = state_r;
        main_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        main_clr_s       = 1'b0;
        skid_load_s      = 1'b0;
        skid_clr_s       = 1'b0;
        if (flush) begin
            next_state_s = EMPTY;
            main_clr_s   = 1'b1;
            skid_clr_s   = 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (acc_s) begin
                        main_load_s  = 1'b1;
                        next_state_s = ONE;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (acc_s && emi_s) begin
                        main_load_s  = 1'b1;
                        next_state_s = ONE;
                    end else if (acc_s) begin
                        skid_load_s  = 1'b1;
                        next_state_s = TWO;
                    end else if (emi_s) begin
                        // Leaving a bubble behind: ctrl drops to zero.
                        main_clr_s   = 1'b1;
                        next_state_s = EMPTY;
                    end else begin
                        next_state_s = ONE;
                    end
                end
                TWO: begin
                    if (emi_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clr_s       = 1'b1;
                        next_state_s     = ONE;
                    end else begin
                        next_state_s = TWO;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                    main_clr_s   = 1'b1;
                    skid_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // Source of the main entry: the skid entry when draining, else upstream.
    always_comb begin
        main_d_ctrl_s = in_ctrl;
        main_d_data_s = in_data;
        if (main_from_skid_s) begin
            main_d_ctrl_s = skid_ctrl_s;
            main_d_data_s = skid_data_s;
        end else begin
            main_d_ctrl_s = in_ctrl;
            main_d_data_s = in_data;
        end
    end

    // State register plus handshake flops derived from the next state, so
    // both in_ready and out_valid come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= stage_accepts(next_state_s);
            out_valid_r <= stage_occupied(next_state_s);
        end
    end

    // Back-pressure counter; flush leaves it alone, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    pipe_entry #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load_s),
        .ctrl_clear(main_clr_s),
        .d_ctrl    (main_d_ctrl_s),
        .d_data    (main_d_data_s),
        .q_ctrl    (main_ctrl_s),
        .q_data    (main_data_s)
    );

    pipe_entry #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_s),
        .ctrl_clear(skid_clr_s),
        .d_ctrl    (in_ctrl),
        .d_data    (in_data),
        .q_ctrl    (skid_ctrl_s),
        .q_data    (skid_data_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_ctrl  = main_ctrl_s;
    assign out_data  = main_data_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-based occupancy model. A second instance with a
// 3-bit counter covers stall counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int CW   = 4;
    localparam int DW   = 101;
    localparam int NW   = 16;
    localparam int CMAX = 65535;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [CW-1:0] s_in_ctrl;
    logic [DW-1:0] s_in_data;
    logic          s_flush;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [2:0]    s_stall_cnt;

    int            n_checks;
    int            n_fail;

    beat_t         mq[$];
    logic [DW-1:0] m_last;
    int            m_cnt;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_ctrl  (s_in_ctrl),
        .in_data  (s_in_data),
        .flush    (s_flush),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_ctrl (s_out_ctrl),
        .out_data (s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl, input logic r,
                         output logic accepted);
        logic          m_ov;
        logic          acc;
        logic          emi;
        logic [DW-1:0] shown;
        beat_t         b;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        m_ov  = (mq.size() > 0);
        acc   = v && (mq.size() < 2);
        emi   = m_ov && ordy;
        shown = m_ov ? mq[0].data : m_last;
        accepted = acc && !fl && !r;
        b.ctrl = c;
        b.data = d;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            if (m_ov && !ordy && m_cnt < CMAX) m_cnt++;
            m_last = shown;
            if (fl) begin
                mq.delete();
            end else begin
                if (emi) void'(mq.pop_front());
                if (acc) mq.push_back(b);
            end
        end
        #1;
        check_val("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        check_val("in_ready",  128'(in_ready),  128'(mq.size() < 2));
        check_val("out_ctrl",  128'(out_ctrl),  (mq.size() > 0) ? 128'(mq[0].ctrl) : 128'(0));
        check_val("out_data",  128'(out_data),  (mq.size() > 0) ? 128'(mq[0].data) : 128'(m_last));
        check_val("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
    endtask

    initial begin
        logic a;
        logic [DW-1:0] cdata;
        n_checks = 0;
        n_fail   = 0;
        m_last   = '0;
        m_cnt    = 0;
        s_in_valid  = 1'b0;
        s_in_ctrl   = '0;
        s_in_data   = '0;
        s_flush     = 1'b0;
        s_out_ready = 1'b1;

        // Reset state
        cycle(1'b0, 4'h0, '0, 1'b1, 1'b0, 1'b1, a);
        cycle(1'b0, 4'h0, '0, 1'b1, 1'b0, 1'b1, a);
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_in_ready", 128'(in_ready), 128'(1));
        check_val("rst_out_data", 128'(out_data), 128'(0));

        // Single beat, visible the next cycle, bubble after
        cycle(1'b1, 4'b1011, 101'h5, 1'b1, 1'b0, 1'b0, a);
        check_val("beat_ctrl", 128'(out_ctrl), 128'(4'b1011));
        check_val("beat_data", 128'(out_data), 128'(5));
        cycle(1'b0, 4'h0, '0, 1'b1, 1'b0, 1'b0, a);
        check_val("bubble_valid", 128'(out_valid), 128'(0));
        check_val("bubble_ctrl", 128'(out_ctrl), 128'(0));

        // Streaming 1..8 at full throughput
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 4'(i), 101'(i), 1'b1, 1'b0, 1'b0, a);
            check_val("stream_data", 128'(out_data), 128'(i));
        end
        cycle(1'b0, 4'h0, '0, 1'b1, 1'b0, 1'b0, a);

        // Back-pressure with A, B, C, then release
        cycle(1'b1, 4'hA, 101'hA, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 4'hB, 101'hB, 1'b0, 1'b0, 1'b0, a);
        check_val("bp_in_ready", 128'(in_ready), 128'(0));
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'hC, 101'hC, 1'b0, 1'b0, 1'b0, a);
        check_val("bp_hold_a", 128'(out_data), 128'(101'hA));
        a = 1'b0;
        for (int i = 0; i < 10 && !a; i++) cycle(1'b1, 4'hC, 101'hC, 1'b1, 1'b0, 1'b0, a);
        check_val("bp_c_accepted", 128'(a), 128'(1));
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, '0, 1'b1, 1'b0, 1'b0, a);

        // Flush while holding two beats, with D offered
        cycle(1'b1, 4'h1, 101'h11, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 4'h2, 101'h22, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 4'hD, 101'hD, 1'b0, 1'b1, 1'b0, a);
        check_val("flush_valid", 128'(out_valid), 128'(0));
        check_val("flush_ctrl", 128'(out_ctrl), 128'(0));
        check_val("flush_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, '0, 1'b1, 1'b0, 1'b0, a);

        // Reset while holding two beats, then a normal beat
        cycle(1'b1, 4'h3, 101'h33, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 4'h4, 101'h44, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b1, a);
        check_val("rst2_cnt", 128'(stall_cnt), 128'(0));
        check_val("rst2_data", 128'(out_data), 128'(0));
        cycle(1'b1, 4'h6, 101'h66, 1'b1, 1'b0, 1'b0, a);
        check_val("rst2_beat", 128'(out_data), 128'(101'h66));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 70, 4'($urandom), rnd_data(),
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) == 0, a);
        end

        // Saturation on a 3-bit counter
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_ctrl   = 4'h7;
        s_in_data   = 101'h77;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check_val("sat_valid", 128'(s_out_valid), 128'(1));
        check_val("sat_cnt0", 128'(s_stall_cnt), 128'(0));
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check_val("sat_cnt", 128'(s_stall_cnt), 128'((i < 7) ? i : 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
